ofs_plat_axi_mem_rd_credit_arb: RTL

Two-requester AXI read-address arbiter with read-response credit management. It sits upstream of the clock-crossing read reorder buffer, which does no credit management of its own. The block grants AR requests only when enough response-beat credits remain, so the ROB's unconditional rready is always safe. It tags each granted request with its requester index in the ID MSB and demultiplexes the sorted R stream back to the owning requester.

---
 rtl/ofs_plat_axi_mem_rd_credit_arb.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/ofs_plat_axi_mem_rd_credit_arb.sv
// Two-requester AXI AR arbiter that only grants when the downstream ROB has room
// for the whole burst, tags the ID with the requester index, and demuxes R back.
module ofs_plat_axi_mem_rd_credit_arb #(
    parameter int ID_WIDTH         = 8,
    parameter int LEN_WIDTH        = 8,
    parameter int AR_PAYLOAD_WIDTH = 64,
    parameter int R_PAYLOAD_WIDTH  = 512,
    parameter int NUM_READ_CREDITS = 256,
    // Defaulted so that a full-length burst always fits under the per-requester cap.
    parameter int MAX_PER_REQ      = 256
) (
    input  logic                                      clk,
    input  logic                                      reset,

    input  logic                                      s0_arvalid,
    output logic                                      s0_arready,
    input  logic [ID_WIDTH-1:0]                       s0_ar_id,
    input  logic [LEN_WIDTH-1:0]                      s0_ar_len,
    input  logic [AR_PAYLOAD_WIDTH-1:0]               s0_ar_payload,

    input  logic                                      s1_arvalid,
    output logic                                      s1_arready,
    input  logic [ID_WIDTH-1:0]                       s1_ar_id,
    input  logic [LEN_WIDTH-1:0]                      s1_ar_len,
    input  logic [AR_PAYLOAD_WIDTH-1:0]               s1_ar_payload,

    output logic                                      m_arvalid,
    input  logic                                      m_arready,
    output logic [ID_WIDTH:0]                         m_ar_id,
    output logic [LEN_WIDTH-1:0]                      m_ar_len,
    output logic [AR_PAYLOAD_WIDTH-1:0]               m_ar_payload,

    input  logic                                      m_rvalid,
    output logic                                      m_rready,
    input  logic [ID_WIDTH:0]                         m_r_id,
    input  logic                                      m_r_last,
    input  logic [R_PAYLOAD_WIDTH-1:0]                m_r_payload,

    output logic                                      s0_rvalid,
    input  logic                                      s0_rready,
    output logic [ID_WIDTH-1:0]                       s0_r_id,
    output logic                                      s0_r_last,
    output logic [R_PAYLOAD_WIDTH-1:0]                s0_r_payload,

    output logic                                      s1_rvalid,
    input  logic                                      s1_rready,
    output logic [ID_WIDTH-1:0]                       s1_r_id,
    output logic                                      s1_r_last,
    output logic [R_PAYLOAD_WIDTH-1:0]                s1_r_payload,

    output logic [$clog2(NUM_READ_CREDITS+1)-1:0]     credits_free,
    output logic [$clog2(MAX_PER_REQ+1)-1:0]          s0_outstanding,
    output logic [$clog2(MAX_PER_REQ+1)-1:0]          s1_outstanding
);

    localparam int CW = $clog2(NUM_READ_CREDITS + 1);
    localparam int OW = $clog2(MAX_PER_REQ + 1);
    localparam int BW = LEN_WIDTH + 1;

    if (!(((1 << LEN_WIDTH) <= MAX_PER_REQ) && (MAX_PER_REQ <= NUM_READ_CREDITS))) begin : g_bad_params
        $fatal(1, "ofs_plat_axi_mem_rd_credit_arb: need (1<<LEN_WIDTH) <= MAX_PER_REQ <= NUM_READ_CREDITS");
    end

    logic [CW-1:0]               credits_q, credits_d;
    logic [OW-1:0]               out0_q, out0_d;
    logic [OW-1:0]               out1_q, out1_d;
    logic                        last_q;
    logic                        mvld_q;
    logic [ID_WIDTH:0]           mid_q;
    logic [LEN_WIDTH-1:0]        mlen_q;
    logic [AR_PAYLOAD_WIDTH-1:0] mpl_q;

    logic [BW-1:0] beats0, beats1, beats_g;
    logic          elig0, elig1, load, gnt0, gnt1, gnt;
    logic          sel, rbeat, ret0, ret1, ret;

    // Extra bit keeps len+1 exact even for an all-ones len.
    assign beats0 = BW'(s0_ar_len) + BW'(1);
    assign beats1 = BW'(s1_ar_len) + BW'(1);

    assign elig0 = s0_arvalid
                && (32'(beats0) <= 32'(credits_q))
                && (32'(out0_q) + 32'(beats0) <= 32'(MAX_PER_REQ));
    assign elig1 = s1_arvalid
                && (32'(beats1) <= 32'(credits_q))
                && (32'(out1_q) + 32'(beats1) <= 32'(MAX_PER_REQ));

    // last_q = 1 means s1 won most recently, so s0 takes a tie.
    assign load = !mvld_q || m_arready;
    assign gnt0 = !reset && load && elig0 && (!elig1 || last_q);
    assign gnt1 = !reset && load && elig1 && !gnt0;
    assign gnt  = gnt0 || gnt1;

    assign s0_arready = gnt0;
    assign s1_arready = gnt1;

    assign m_arvalid    = mvld_q;
    assign m_ar_id      = mid_q;
    assign m_ar_len     = mlen_q;
    assign m_ar_payload = mpl_q;

    assign sel       = m_r_id[ID_WIDTH];
    assign s0_rvalid = m_rvalid && !sel;
    assign s1_rvalid = m_rvalid && sel;
    assign m_rready  = sel ? s1_rready : s0_rready;

    assign s0_r_id      = m_r_id[ID_WIDTH-1:0];
    assign s1_r_id      = m_r_id[ID_WIDTH-1:0];
    assign s0_r_last    = m_r_last;
    assign s1_r_last    = m_r_last;
    assign s0_r_payload = m_r_payload;
    assign s1_r_payload = m_r_payload;

    // A beat for a requester with nothing outstanding is ignored so counters never wrap.
    assign rbeat = m_rvalid && m_rready;
    assign ret0  = rbeat && !sel && (out0_q != '0);
    assign ret1  = rbeat && sel && (out1_q != '0);
    assign ret   = ret0 || ret1;

    assign beats_g = gnt0 ? beats0 : (gnt1 ? beats1 : '0);

    assign credits_d = CW'(32'(credits_q) - 32'(beats_g) + 32'(ret));
    assign out0_d    = OW'(32'(out0_q) + (gnt0 ? 32'(beats0) : 32'd0) - 32'(ret0));
    assign out1_d    = OW'(32'(out1_q) + (gnt1 ? 32'(beats1) : 32'd0) - 32'(ret1));

    assign credits_free   = credits_q;
    assign s0_outstanding = out0_q;
    assign s1_outstanding = out1_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credits_q <= CW'(NUM_READ_CREDITS);
            out0_q    <= '0;
            out1_q    <= '0;
            last_q    <= 1'b1;
            mvld_q    <= 1'b0;
            mid_q     <= '0;
            mlen_q    <= '0;
            mpl_q     <= '0;
        end else begin
            credits_q <= credits_d;
            out0_q    <= out0_d;
            out1_q    <= out1_d;
            if (gnt) begin
                last_q <= gnt1;
            end
            if (load) begin
                mvld_q <= gnt;
            end
            if (gnt) begin
                mid_q  <= gnt1 ? {1'b1, s1_ar_id} : {1'b0, s0_ar_id};
                mlen_q <= gnt1 ? s1_ar_len : s0_ar_len;
                mpl_q  <= gnt1 ? s1_ar_payload : s0_ar_payload;
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && rbeat && ((!sel && out0_q == '0) || (sel && out1_q == '0))) begin
            $fatal(1, "ofs_plat_axi_mem_rd_credit_arb: R beat for requester %0d with no outstanding beats", sel);
        end
    end
`endif

endmodule
